nibble_serial_addsub_ctrl: RTL

Multi-cycle controller that performs a WIDTH-bit add or subtract using one 4-bit carry-lookahead add slice. It processes one nibble per cycle, least significant nibble first, and carries the slice's carry-out between nibbles in a register. It is an area-reduced ALU add/sub unit: the requester pulses start and gets back result, flags and a one-cycle done pulse. A single instantiated 4-bit CLA slice (A, B, Cin in; Sum, Cout out) is the only adder in the block.

---
 rtl/nibble_serial_addsub_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/nibble_serial_addsub_ctrl.sv
// -----------------------------------------------------------------------------
// nibble_serial_addsub_ctrl
//
// Purpose:
//   WIDTH-bit add/subtract unit that reuses a single 4-bit carry-lookahead
//   slice. It processes one nibble per clock, least significant nibble first,
//   and keeps the slice carry-out in a register between nibbles. A request is
//   a one-cycle start pulse. The unit answers with a one-cycle done pulse
//   together with the registered result and flags.
//
// Optional feature (compile-time macro):
//   ADDSUB_SAT_EN - when defined, a signed overflow saturates the result to the
//                   most positive or most negative value. flag_z and flag_n
//                   follow the saturated value. cout and flag_v still report
//                   the raw carry and the raw overflow.
//
// Ports (nibble_serial_addsub_ctrl):
//   clk      in   1      rising-edge clock
//   rst      in   1      asynchronous active-high reset
//   start    in   1      request, sampled only in IDLE or DONE
//   op_sub   in   1      0 = a+b, 1 = a-b, sampled with start
//   a, b     in   WIDTH  operands, sampled with start
//   busy     out  1      high while the nibble loop runs
//   done     out  1      one-cycle completion pulse
//   result   out  WIDTH  registered result, held between operations
//   cout     out  1      raw carry-out of the most significant nibble
//   flag_z   out  1      result == 0
//   flag_n   out  1      result[WIDTH-1]
//   flag_v   out  1      signed overflow
//
// Ports (nibble_serial_addsub_cla4):
//   i_a, i_b in   4      nibble operands
//   i_cin    in   1      carry-in
//   o_sum    out  4      nibble sum
//   o_cout   out  1      carry-out
// -----------------------------------------------------------------------------

module nibble_serial_addsub_cla4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [3:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // All carries are flattened generate/propagate terms, so no ripple path
    // runs through the slice.
    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_cin);
    assign o_cout = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);
    assign o_sum  = w_p ^ w_c;
endmodule

module nibble_serial_addsub_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = $clog2(NIB);
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-5:0] r_acc;    // lower nibbles; the top nibble goes straight to result
    logic             r_carry;
    logic [IW-1:0]    r_idx;

    logic [3:0]       w_sum;
    logic             w_cout;
    logic             w_cap;
    logic             w_last;
    logic             w_ovf;
    logic [WIDTH-1:0] w_raw;
    logic [WIDTH-1:0] w_final;

    nibble_serial_addsub_cla4 u_slice (
        .i_a    (r_opa[4*r_idx +: 4]),
        .i_b    (r_opb[4*r_idx +: 4]),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // A new request is taken in any state except RUN.
    assign w_cap  = start && (r_state != S_RUN);
    assign w_last = (r_state == S_RUN) && (r_idx == LAST);
    assign w_raw  = {w_sum, r_acc};
    // Overflow occurs when the operands share a sign and the sum has the other sign.
    // r_opb is already inverted for a subtract.
    assign w_ovf  = (r_opa[WIDTH-1] == r_opb[WIDTH-1]) && (w_sum[3] != r_opa[WIDTH-1]);

`ifdef ADDSUB_SAT_EN
    assign w_final = !w_ovf          ? w_raw :
                     r_opa[WIDTH-1]  ? {1'b1, {(WIDTH-1){1'b0}}} :
                                       {1'b0, {(WIDTH-1){1'b1}}};
`else
    assign w_final = w_raw;
`endif

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);

    always_comb begin
        // NOTE: assign the default first so that no path leaves w_next
        // unassigned. Otherwise synthesis would infer a latch.
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (r_idx == LAST) w_next = S_DONE;
            S_DONE:  w_next = start ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: state registers take non-blocking assignments, so every
            // flop samples its pre-edge inputs regardless of block order.
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the operand and assembly registers are reset as well.
            // They are few, and this keeps the slice inputs defined while idle.
            r_opa   <= '0;
            r_opb   <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            result  <= '0;
            cout    <= 1'b0;
            flag_z  <= 1'b0;
            flag_n  <= 1'b0;
            flag_v  <= 1'b0;
        end else if (w_cap) begin
            // A two's-complement subtract is done as a + ~b + 1.
            r_opa   <= a;
            r_opb   <= op_sub ? ~b : b;
            r_carry <= op_sub;
            r_idx   <= '0;
        end else if (r_state == S_RUN) begin
            r_carry <= w_cout;
            if (w_last) begin
                r_idx  <= '0;
                result <= w_final;
                cout   <= w_cout;
                flag_v <= w_ovf;
                flag_z <= (w_final == '0);
                flag_n <= w_final[WIDTH-1];
            end else begin
                r_acc[4*r_idx +: 4] <= w_sum;
                r_idx               <= r_idx + 1'b1;
            end
        end
    end
endmodule
